// File: rtl/frame_pad_inserter.sv
`timescale 1ns/1ps
// Frame border inserter: wraps each frame in a (KERNEL_SIZE-1)/2 pad ring (zero, constant or edge replicate).
// Latency: single output register, an accepted pixel appears on oData the following cycle.
// Backpressure: oData/oIsPad/counters hold while oValid&!iReady; oReady only asserted when the output slot frees.
module frame_pad_inserter #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 3,
    parameter int DW          = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   newFrame,
    input  logic [1:0]             mode,
    input  logic [DW-1:0]          padValue,
    input  logic                   iValid,
    input  logic [CHANNELS*DW-1:0] iData,
    output logic                   oReady,
    output logic                   oValid,
    output logic [CHANNELS*DW-1:0] oData,
    input  logic                   iReady,
    output logic                   oIsPad,
    output logic [15:0]            oXCnt,
    output logic [15:0]            oYCnt,
    output logic                   oDone
);

    localparam int B  = (KERNEL_SIZE - 1) / 2;
    localparam int OW = WIDTH + 2 * B;
    localparam int PW = CHANNELS * DW;
    localparam logic [31:0] BAND_PADS = 32'(B * OW);
    localparam logic [31:0] SIDE_PADS = 32'(B);

    typedef enum logic [2:0] {
        S_IDLE, S_TOP, S_LEFT, S_BODY, S_RIGHT, S_BOTTOM, S_DONE
    } fsmStateT;

    fsmStateT state, nextState;

    logic [1:0]    modeR;
    logic [DW-1:0] padR;
    logic [PW-1:0] firstPix;
    logic [PW-1:0] lastPix;
    logic          haveFirst;
    logic [31:0]   padCnt;
    logic [15:0]   colAcc;
    logic [15:0]   rowCnt;
    logic [15:0]   xPos;
    logic [15:0]   yPos;

    logic          advance;
    logic          acceptState;
    logic          accept;
    logic          replicate;
    logic          lastRow;
    logic          lastCol;
    logic [PW-1:0] constPad;

    logic          loadEn;
    logic [PW-1:0] loadDat;
    logic          loadPad;
    logic          padStep;
    logic          rowDone;

    assign advance   = !oValid || iReady;
    assign replicate = (modeR == 2'd2);
    assign constPad  = (modeR == 2'd1) ? {CHANNELS{padR}} : '0;
    assign lastRow   = (rowCnt == 16'(HEIGHT - 1));
    assign lastCol   = (colAcc == 16'(WIDTH - 1));

    // Replicate mode must see the row's first pixel before it can emit the left border.
    assign acceptState = (state == S_BODY) || (state == S_LEFT && replicate && !haveFirst);
    assign oReady      = acceptState && advance;
    assign accept      = iValid && oReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: begin
                if (newFrame) nextState = (B > 0) ? S_TOP : S_BODY;
            end
            S_TOP: begin
                if (advance && padCnt == BAND_PADS - 32'd1) nextState = S_LEFT;
            end
            S_LEFT: begin
                if (replicate) begin
                    if (haveFirst && advance && padCnt == SIDE_PADS)
                        nextState = (WIDTH == 1) ? S_RIGHT : S_BODY;
                end else if (advance && padCnt == SIDE_PADS - 32'd1) begin
                    nextState = S_BODY;
                end
            end
            S_BODY: begin
                if (accept && lastCol) begin
                    if (B > 0)        nextState = S_RIGHT;
                    else if (lastRow) nextState = S_DONE;
                end
            end
            S_RIGHT: begin
                if (advance && padCnt == SIDE_PADS - 32'd1)
                    nextState = lastRow ? S_BOTTOM : S_LEFT;
            end
            S_BOTTOM: begin
                if (advance && padCnt == BAND_PADS - 32'd1) nextState = S_DONE;
            end
            S_DONE: begin
                if (advance) nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        loadEn  = 1'b0;
        loadDat = '0;
        loadPad = 1'b0;
        padStep = 1'b0;
        rowDone = 1'b0;
        case (state)
            S_TOP, S_BOTTOM: begin
                loadEn  = advance;
                loadDat = constPad;
                loadPad = 1'b1;
                padStep = advance;
            end
            S_LEFT: begin
                if (replicate) begin
                    // B copies of the captured pixel, then the pixel itself as real data.
                    loadEn  = haveFirst && advance;
                    loadDat = firstPix;
                    loadPad = (padCnt < SIDE_PADS);
                    padStep = haveFirst && advance;
                end else begin
                    loadEn  = advance;
                    loadDat = constPad;
                    loadPad = 1'b1;
                    padStep = advance;
                end
            end
            S_BODY: begin
                loadEn  = accept;
                loadDat = iData;
                rowDone = (B == 0) && accept && lastCol;
            end
            S_RIGHT: begin
                loadEn  = advance;
                loadDat = replicate ? lastPix : constPad;
                loadPad = 1'b1;
                padStep = advance;
                rowDone = advance && (padCnt == SIDE_PADS - 32'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            modeR     <= 2'd0;
            padR      <= '0;
            firstPix  <= '0;
            lastPix   <= '0;
            haveFirst <= 1'b0;
            padCnt    <= '0;
            colAcc    <= '0;
            rowCnt    <= '0;
            xPos      <= '0;
            yPos      <= '0;
        end else if (state == S_IDLE) begin
            haveFirst <= 1'b0;
            padCnt    <= '0;
            colAcc    <= '0;
            rowCnt    <= '0;
            xPos      <= '0;
            yPos      <= '0;
            if (newFrame) begin
                modeR <= mode;
                padR  <= padValue;
            end
        end else begin
            if (state != nextState) padCnt <= '0;
            else if (padStep)       padCnt <= padCnt + 32'd1;

            if (nextState != S_LEFT) haveFirst <= 1'b0;
            else if (accept)         haveFirst <= 1'b1;

            if (accept) begin
                colAcc  <= lastCol ? 16'd0 : colAcc + 16'd1;
                lastPix <= iData;
                if (state == S_LEFT) firstPix <= iData;
            end

            if (rowDone) rowCnt <= rowCnt + 16'd1;

            if (loadEn) begin
                if (xPos == 16'(OW - 1)) begin
                    xPos <= '0;
                    yPos <= yPos + 16'd1;
                end else begin
                    xPos <= xPos + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oValid <= 1'b0;
            oData  <= '0;
            oIsPad <= 1'b0;
            oXCnt  <= '0;
            oYCnt  <= '0;
            oDone  <= 1'b0;
        end else begin
            // DONE only advances once the final beat has drained.
            oDone <= (state == S_DONE) && advance;
            if (loadEn) begin
                oValid <= 1'b1;
                oData  <= loadDat;
                oIsPad <= loadPad;
                oXCnt  <= xPos;
                oYCnt  <= yPos;
            end else begin
                if (advance) oValid <= 1'b0;
                if (state == S_IDLE) begin
                    oXCnt <= '0;
                    oYCnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_pad_inserter.sv
`timescale 1ns/1ps
// Bench for frame_pad_inserter: randomized framing/backpressure checked against a per-pixel frame model.
module tb_frame_pad_inserter;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, nf3, nf1, iValid, iReady;
    logic [1:0]  mode;
    logic [7:0]  padValue;
    logic [23:0] iData;

    logic        r3, v3, p3, dn3, r1, v1, p1, dn1;
    logic [23:0] d3, d1;
    logic [15:0] x3, y3, x1, y1;

    logic        oReady, oValid, oIsPad, oDone;
    logic [23:0] oData;
    logic [15:0] oXCnt, oYCnt;
    int          sel = 3;

    frame_pad_inserter #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(3), .CHANNELS(3), .DW(8)) dut3 (
        .clk(clk), .reset(reset), .newFrame(nf3), .mode(mode), .padValue(padValue),
        .iValid(iValid), .iData(iData), .oReady(r3), .oValid(v3), .oData(d3),
        .iReady(iReady), .oIsPad(p3), .oXCnt(x3), .oYCnt(y3), .oDone(dn3));

    frame_pad_inserter #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(1), .CHANNELS(3), .DW(8)) dut1 (
        .clk(clk), .reset(reset), .newFrame(nf1), .mode(mode), .padValue(padValue),
        .iValid(iValid), .iData(iData), .oReady(r1), .oValid(v1), .oData(d1),
        .iReady(iReady), .oIsPad(p1), .oXCnt(x1), .oYCnt(y1), .oDone(dn1));

    always_comb begin
        if (sel == 1) begin
            oReady = r1; oValid = v1; oData = d1; oIsPad = p1; oXCnt = x1; oYCnt = y1; oDone = dn1;
        end else begin
            oReady = r3; oValid = v3; oData = d3; oIsPad = p3; oXCnt = x3; oYCnt = y3; oDone = dn3;
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    logic [23:0] pix[$];
    logic [23:0] expD[$];
    bit          expP[$];
    int          expX[$], expY[$];
    logic [23:0] gotD[$];
    bit          gotP[$];
    int          gotX[$], gotY[$];
    int          gotAccepts, doneCnt, doneCycle, lastBeatCycle, stallViol, doneWithValid, timedOut;

    // kind 0: 1..N, kind 1: random, kind 2: first row 10,20,30,40 then random
    task automatic set_pixels(int kind);
        pix = {};
        for (int i = 0; i < W * H; i++) begin
            if (kind == 0)                pix.push_back(24'(i + 1));
            else if (kind == 2 && i < W)  pix.push_back(24'(10 * (i + 1)));
            else                          pix.push_back(24'($urandom));
        end
    endtask

    // Reference frame: every output coordinate classified directly from the border geometry.
    task automatic build_expected(int m, logic [7:0] pv, int b);
        int ow, oh, r;
        logic [23:0] padv;
        ow = W + 2 * b;
        oh = H + 2 * b;
        padv = (m == 1) ? {3{pv}} : 24'h0;
        expD = {}; expP = {}; expX = {}; expY = {};
        for (int y = 0; y < oh; y++) begin
            for (int x = 0; x < ow; x++) begin
                r = y - b;
                expX.push_back(x);
                expY.push_back(y);
                if (y < b || y >= b + H) begin
                    expD.push_back(padv); expP.push_back(1'b1);
                end else if (x < b) begin
                    expD.push_back((m == 2) ? pix[r * W] : padv); expP.push_back(1'b1);
                end else if (x >= b + W) begin
                    expD.push_back((m == 2) ? pix[r * W + W - 1] : padv); expP.push_back(1'b1);
                end else begin
                    expD.push_back(pix[r * W + x - b]); expP.push_back(1'b0);
                end
            end
        end
    endtask

    // Drives one frame into the selected DUT and records every beat; no checking here.
    task automatic run_frame(int m, logic [7:0] pv, int vPct, int rPct, int abortAt);
        int pIdx;
        bit holdV, prevStall;
        logic [23:0] prevD;
        logic prevP;
        logic [15:0] prevX, prevY;
        gotD = {}; gotP = {}; gotX = {}; gotY = {};
        gotAccepts = 0; doneCnt = 0; doneCycle = -1; lastBeatCycle = -1;
        stallViol = 0; doneWithValid = 0; timedOut = 0;
        pIdx = 0; holdV = 0; prevStall = 0;
        prevD = '0; prevP = 0; prevX = '0; prevY = '0;
        @(negedge clk);
        mode = 2'(m); padValue = pv; iValid = 0; iReady = 1;
        if (sel == 1) nf1 = 1; else nf3 = 1;
        @(negedge clk);
        nf1 = 0; nf3 = 0;
        mode = 2'($urandom); padValue = 8'($urandom);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iReady = ($urandom_range(99) < rPct);
            if (!holdV) iValid = (pIdx < pix.size()) && ($urandom_range(99) < vPct);
            iData = (pIdx < pix.size()) ? pix[pIdx] : 24'($urandom);
            if (sel == 1) nf1 = (cyc == 5); else nf3 = (cyc == 5);
            #1;
            if (prevStall && (oData !== prevD || oIsPad !== prevP || oXCnt !== prevX || oYCnt !== prevY))
                stallViol++;
            if (oValid && !iReady && oReady) stallViol++;
            if (oDone) begin
                doneCnt++;
                doneCycle = cyc;
                if (oValid) doneWithValid++;
            end
            if (oValid && iReady) begin
                gotD.push_back(oData); gotP.push_back(oIsPad);
                gotX.push_back(int'(oXCnt)); gotY.push_back(int'(oYCnt));
                lastBeatCycle = cyc;
            end
            if (iValid && oReady) begin
                gotAccepts++; pIdx++; holdV = 0;
            end else begin
                holdV = iValid;
            end
            prevStall = oValid && !iReady;
            prevD = oData; prevP = oIsPad; prevX = oXCnt; prevY = oYCnt;
            if (abortAt > 0 && gotD.size() == abortAt) begin
                @(negedge clk);
                reset = 0; iValid = 0; nf1 = 0; nf3 = 0;
                return;
            end
            if (doneCnt > 0 && cyc >= doneCycle + 3) break;
            @(negedge clk);
        end
        nf1 = 0; nf3 = 0; iValid = 0; iReady = 1;
        if (doneCnt == 0) timedOut = 1;
    endtask

    task automatic test_reset();
        sel = 3; reset = 0; nf3 = 0; nf1 = 0; mode = 0; padValue = 0;
        iValid = 1; iReady = 1; iData = 24'h123456;
        repeat (3) @(negedge clk);
        #1;
        nChecks++; if (oValid !== 1'b0) begin nFails++; $display("FAIL reset_oValid actual=%0b required=0", oValid); end
        nChecks++; if (oReady !== 1'b0) begin nFails++; $display("FAIL reset_oReady actual=%0b required=0", oReady); end
        nChecks++; if (oIsPad !== 1'b0) begin nFails++; $display("FAIL reset_oIsPad actual=%0b required=0", oIsPad); end
        nChecks++; if (oDone !== 1'b0) begin nFails++; $display("FAIL reset_oDone actual=%0b required=0", oDone); end
        nChecks++; if (oData !== 24'h0) begin nFails++; $display("FAIL reset_oData actual=%h required=0", oData); end
        nChecks++; if (oXCnt !== 16'h0 || oYCnt !== 16'h0) begin nFails++; $display("FAIL reset_counters actual=%0d,%0d required=0,0", oXCnt, oYCnt); end
        nChecks++; if (v1 !== 1'b0 || r1 !== 1'b0) begin nFails++; $display("FAIL reset_k1 actual=%0b%0b required=00", v1, r1); end
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        nChecks++; if (oValid !== 1'b0 || oReady !== 1'b0) begin nFails++; $display("FAIL idle_quiet actual=%0b%0b required=00", oValid, oReady); end
        iValid = 0;
    endtask

    task automatic test_zero_pad();
        int pads;
        sel = 3;
        set_pixels(0);
        build_expected(0, 8'h00, 1);
        run_frame(0, 8'h00, 100, 100, 0);
        nChecks++; if (timedOut !== 0) begin nFails++; $display("FAIL zero_timeout actual=%0d required=0", timedOut); end
        nChecks++; if (gotD.size() !== 24) begin nFails++; $display("FAIL zero_beats actual=%0d required=24", gotD.size()); end
        pads = 0;
        for (int i = 0; i < gotD.size() && i < expD.size(); i++) begin
            pads += gotP[i];
            nChecks++; if (gotD[i] !== expD[i]) begin nFails++; $display("FAIL zero_data[%0d] actual=%h required=%h", i, gotD[i], expD[i]); end
            nChecks++; if (gotP[i] !== expP[i]) begin nFails++; $display("FAIL zero_pad[%0d] actual=%0b required=%0b", i, gotP[i], expP[i]); end
            nChecks++; if (gotX[i] !== expX[i] || gotY[i] !== expY[i]) begin nFails++; $display("FAIL zero_pos[%0d] actual=%0d,%0d required=%0d,%0d", i, gotX[i], gotY[i], expX[i], expY[i]); end
        end
        nChecks++; if (pads !== 16) begin nFails++; $display("FAIL zero_padcount actual=%0d required=16", pads); end
        nChecks++; if (gotAccepts !== 8) begin nFails++; $display("FAIL zero_accepts actual=%0d required=8", gotAccepts); end
        nChecks++; if (doneCnt !== 1) begin nFails++; $display("FAIL zero_donecount actual=%0d required=1", doneCnt); end
        nChecks++; if (doneCycle !== lastBeatCycle + 1) begin nFails++; $display("FAIL zero_donetime actual=%0d required=%0d", doneCycle, lastBeatCycle + 1); end
        nChecks++; if (doneWithValid !== 0) begin nFails++; $display("FAIL zero_donevalid actual=%0d required=0", doneWithValid); end
    endtask

    task automatic test_const_pad();
        sel = 3;
        set_pixels(1);
        build_expected(1, 8'hAA, 1);
        run_frame(1, 8'hAA, 100, 100, 0);
        nChecks++; if (gotD.size() !== 24) begin nFails++; $display("FAIL const_beats actual=%0d required=24", gotD.size()); end
        for (int i = 0; i < gotD.size() && i < expD.size(); i++) begin
            nChecks++; if (gotD[i] !== expD[i] || gotP[i] !== expP[i]) begin nFails++; $display("FAIL const_beat[%0d] actual=%h/%0b required=%h/%0b", i, gotD[i], gotP[i], expD[i], expP[i]); end
        end
        nChecks++; if (doneCnt !== 1 || doneCycle !== lastBeatCycle + 1) begin nFails++; $display("FAIL const_done actual=%0d@%0d required=1@%0d", doneCnt, doneCycle, lastBeatCycle + 1); end
    endtask

    task automatic test_replicate();
        sel = 3;
        set_pixels(2);
        build_expected(2, 8'h55, 1);
        run_frame(2, 8'h55, 100, 100, 0);
        nChecks++; if (gotD.size() !== 24) begin nFails++; $display("FAIL repl_beats actual=%0d required=24", gotD.size()); end
        for (int i = 0; i < gotD.size() && i < expD.size(); i++) begin
            nChecks++; if (gotD[i] !== expD[i] || gotP[i] !== expP[i]) begin nFails++; $display("FAIL repl_beat[%0d] actual=%h/%0b required=%h/%0b", i, gotD[i], gotP[i], expD[i], expP[i]); end
            nChecks++; if (gotX[i] !== expX[i] || gotY[i] !== expY[i]) begin nFails++; $display("FAIL repl_pos[%0d] actual=%0d,%0d required=%0d,%0d", i, gotX[i], gotY[i], expX[i], expY[i]); end
        end
        nChecks++; if (gotAccepts !== 8) begin nFails++; $display("FAIL repl_accepts actual=%0d required=8", gotAccepts); end
        nChecks++; if (doneCnt !== 1 || doneCycle !== lastBeatCycle + 1) begin nFails++; $display("FAIL repl_done actual=%0d@%0d required=1@%0d", doneCnt, doneCycle, lastBeatCycle + 1); end
    endtask

    task automatic test_backpressure();
        int m;
        sel = 3;
        for (int f = 0; f < 4; f++) begin
            m = (f == 0) ? 0 : int'($urandom_range(3));
            set_pixels(f == 0 ? 0 : 1);
            build_expected(m == 3 ? 0 : m, 8'h3C, 1);
            run_frame(m, 8'h3C, 60, 50, 0);
            nChecks++; if (timedOut !== 0 || gotD.size() !== 24) begin nFails++; $display("FAIL bp_beats f%0d actual=%0d required=24", f, gotD.size()); end
            for (int i = 0; i < gotD.size() && i < expD.size(); i++) begin
                nChecks++; if (gotD[i] !== expD[i] || gotP[i] !== expP[i] || gotX[i] !== expX[i] || gotY[i] !== expY[i])
                    begin nFails++; $display("FAIL bp_beat f%0d[%0d] actual=%h/%0b@%0d,%0d required=%h/%0b@%0d,%0d", f, i, gotD[i], gotP[i], gotX[i], gotY[i], expD[i], expP[i], expX[i], expY[i]); end
            end
            nChecks++; if (stallViol !== 0) begin nFails++; $display("FAIL bp_stall f%0d actual=%0d required=0", f, stallViol); end
            nChecks++; if (gotAccepts !== 8) begin nFails++; $display("FAIL bp_accepts f%0d actual=%0d required=8", f, gotAccepts); end
            nChecks++; if (doneCnt !== 1 || doneCycle !== lastBeatCycle + 1 || doneWithValid !== 0) begin nFails++; $display("FAIL bp_done f%0d actual=%0d@%0d required=1@%0d", f, doneCnt, doneCycle, lastBeatCycle + 1); end
        end
    endtask

    task automatic test_mid_reset();
        int strayBeats;
        sel = 3;
        set_pixels(0);
        build_expected(0, 8'h00, 1);
        run_frame(0, 8'h00, 100, 100, 9);
        for (int i = 0; i < gotD.size() && i < expD.size(); i++) begin
            nChecks++; if (gotD[i] !== expD[i]) begin nFails++; $display("FAIL abort_data[%0d] actual=%h required=%h", i, gotD[i], expD[i]); end
        end
        @(negedge clk); #1;
        nChecks++; if (oValid !== 1'b0 || oXCnt !== 16'h0 || oYCnt !== 16'h0) begin nFails++; $display("FAIL abort_reset actual=%0b@%0d,%0d required=0@0,0", oValid, oXCnt, oYCnt); end
        @(negedge clk);
        reset = 1; iValid = 1; iReady = 1;
        strayBeats = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (oValid || oReady) strayBeats++;
        end
        iValid = 0;
        nChecks++; if (strayBeats !== 0) begin nFails++; $display("FAIL abort_quiet actual=%0d required=0", strayBeats); end
        set_pixels(1);
        build_expected(1, 8'h5A, 1);
        run_frame(1, 8'h5A, 80, 80, 0);
        nChecks++; if (gotD.size() !== 24) begin nFails++; $display("FAIL rerun_beats actual=%0d required=24", gotD.size()); end
        nChecks++; if (gotX.size() == 0 || gotX[0] !== 0 || gotY[0] !== 0) begin nFails++; $display("FAIL rerun_origin actual_beats=%0d required first beat at 0,0", gotX.size()); end
        for (int i = 0; i < gotD.size() && i < expD.size(); i++) begin
            nChecks++; if (gotD[i] !== expD[i] || gotP[i] !== expP[i] || gotX[i] !== expX[i] || gotY[i] !== expY[i])
                begin nFails++; $display("FAIL rerun_beat[%0d] actual=%h/%0b@%0d,%0d required=%h/%0b@%0d,%0d", i, gotD[i], gotP[i], gotX[i], gotY[i], expD[i], expP[i], expX[i], expY[i]); end
        end
        nChecks++; if (doneCnt !== 1 || doneCycle !== lastBeatCycle + 1) begin nFails++; $display("FAIL rerun_done actual=%0d@%0d required=1@%0d", doneCnt, doneCycle, lastBeatCycle + 1); end
    endtask

    task automatic test_kernel1();
        int pads;
        sel = 1;
        for (int f = 0; f < 2; f++) begin
            set_pixels(f);
            build_expected(f + 1, 8'hC3, 0);
            run_frame(f + 1, 8'hC3, f == 0 ? 100 : 60, f == 0 ? 100 : 50, 0);
            nChecks++; if (timedOut !== 0 || gotD.size() !== 8) begin nFails++; $display("FAIL k1_beats f%0d actual=%0d required=8", f, gotD.size()); end
            pads = 0;
            for (int i = 0; i < gotD.size() && i < expD.size(); i++) begin
                pads += gotP[i];
                nChecks++; if (gotD[i] !== expD[i] || gotX[i] !== expX[i] || gotY[i] !== expY[i])
                    begin nFails++; $display("FAIL k1_beat f%0d[%0d] actual=%h@%0d,%0d required=%h@%0d,%0d", f, i, gotD[i], gotX[i], gotY[i], expD[i], expX[i], expY[i]); end
            end
            nChecks++; if (pads !== 0) begin nFails++; $display("FAIL k1_pads f%0d actual=%0d required=0", f, pads); end
            nChecks++; if (stallViol !== 0) begin nFails++; $display("FAIL k1_stall f%0d actual=%0d required=0", f, stallViol); end
            nChecks++; if (doneCnt !== 1 || doneCycle !== lastBeatCycle + 1) begin nFails++; $display("FAIL k1_done f%0d actual=%0d@%0d required=1@%0d", f, doneCnt, doneCycle, lastBeatCycle + 1); end
        end
        sel = 3;
    endtask

    initial begin
        test_reset();
        test_zero_pad();
        test_const_pad();
        test_replicate();
        test_backpressure();
        test_mid_reset();
        test_kernel1();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
